// File: rtl/crm_clken_seq.sv
// Clock-enable and reset-sequencing manager on ACLK: per-channel divided enables and phases,
// ordered enable-aligned release of active-low resets, and per-channel soft reset.
module crm_clken_seq #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 4,
  parameter int RST_HOLD = 16,
  parameter int RST_GAP  = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [NUM_CH*DIV_W-1:0] DIV_CFG,
  input  logic [NUM_CH-1:0]       SRST_REQ,
  output logic [NUM_CH-1:0]       CLKEN,
  output logic [NUM_CH-1:0]       CLKPH,
  output logic [NUM_CH-1:0]       RESETN_OUT,
  output logic                    SEQ_DONE
);

  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam int GW = $clog2(RST_GAP) + 1;
  localparam int KW = $clog2(NUM_CH) + 1;

  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);
  localparam logic [GW-1:0] GAP_INIT  = GW'(RST_GAP);
  localparam logic [KW-1:0] LAST_K    = KW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_GAP,
    S_DONE
  } seq_state_t;

  logic [DIV_W-1:0]  cnt     [NUM_CH];
  logic [DIV_W-1:0]  div_act [NUM_CH];
  logic [NUM_CH-1:0] ph;
  logic [NUM_CH-1:0] clken;

  seq_state_t        state;
  logic [HW-1:0]     hold_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [KW-1:0]     k;
  logic              seq_done;
  logic [NUM_CH-1:0] seq_rel;

  logic [NUM_CH-1:0] resetn;
  logic [NUM_CH-1:0] released;
  logic [NUM_CH-1:0] soft_act;
  logic [HW-1:0]     soft_cnt [NUM_CH];

  // Divider: cnt reloads from the divisor committed at the previous terminal count, so a
  // new DIV_CFG value never truncates or stretches a half-period that is already scheduled.
  always_ff @(posedge ACLK) begin
    // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
    if (ARESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= DIV_CFG[i*DIV_W +: DIV_W];
        div_act[i] <= DIV_CFG[i*DIV_W +: DIV_W];
      end
      ph <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt[i] == '0) begin
          cnt[i]     <= div_act[i];
          div_act[i] <= DIV_CFG[i*DIV_W +: DIV_W];
          ph[i]      <= ~ph[i];
        end else begin
          cnt[i] <= cnt[i] - DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block can leave a bit unassigned (no latch).
    clken = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clken[i] = (div_act[i] == '0) || ((cnt[i] == '0) && !ph[i]);
    end
  end

  // Sequencer: hold, then release channels in index order, each on its own enable strobe.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= S_HOLD;
      hold_cnt <= HOLD_INIT;
      gap_cnt  <= '0;
      k        <= '0;
      seq_done <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state <= S_WAIT;
            k     <= '0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        S_WAIT: begin
          if (|seq_rel) begin
            if (k == LAST_K) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_INIT;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_WAIT;
            k     <= k + KW'(1);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_HOLD;
      endcase
    end
  end

  always_comb begin
    seq_rel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      seq_rel[i] = (state == S_WAIT) && (k == KW'(i)) && clken[i];
    end
  end

  // Reset outputs: a soft request beats any release landing in the same cycle, and a request
  // coinciding with the sequencer strobe still marks the channel released so the order advances.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      resetn   <= '0;
      released <= '0;
      soft_act <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        soft_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (SRST_REQ[i] && (released[i] || seq_rel[i])) begin
          resetn[i]   <= 1'b0;
          soft_act[i] <= 1'b1;
          soft_cnt[i] <= HOLD_INIT;
        end else if (seq_rel[i]) begin
          resetn[i] <= 1'b1;
        end else if (soft_act[i]) begin
          if (soft_cnt[i] != '0) begin
            soft_cnt[i] <= soft_cnt[i] - HW'(1);
          end else if (clken[i]) begin
            resetn[i]   <= 1'b1;
            soft_act[i] <= 1'b0;
          end
        end
        if (seq_rel[i]) begin
          released[i] <= 1'b1;
        end
      end
    end
  end

  assign CLKEN      = clken;
  assign CLKPH      = ph;
  assign RESETN_OUT = resetn;
  assign SEQ_DONE   = seq_done;

endmodule

// File: tb/tb_crm_clken_seq.sv
// Scoreboard bench for crm_clken_seq: a timestamp-based reference model predicts every cycle,
// and directed runs are also checked against closed-form expectations.
module tb_crm_clken_seq;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 4;
  localparam int RST_HOLD = 4;
  localparam int RST_GAP  = 2;
  localparam int OW       = 3*NUM_CH + 1;
  localparam int DMAX     = (1 << DIV_W) - 1;

  logic                    ACLK = 1'b0;
  logic                    ARESET = 1'b1;
  logic [NUM_CH*DIV_W-1:0] DIV_CFG = '0;
  logic [NUM_CH-1:0]       SRST_REQ = '0;
  logic [NUM_CH-1:0]       CLKEN, CLKPH, RESETN_OUT;
  logic                    SEQ_DONE;

  crm_clken_seq #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(RST_HOLD), .RST_GAP(RST_GAP)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .DIV_CFG(DIV_CFG), .SRST_REQ(SRST_REQ),
    .CLKEN(CLKEN), .CLKPH(CLKPH), .RESETN_OUT(RESETN_OUT), .SEQ_DONE(SEQ_DONE)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [OW-1:0] exp;
    int            tag;
    int            rc;
    int            mt;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Reference model, kept as absolute cycle timestamps.
  int mt = 0;
  bit m_valid = 0;
  int m_term [NUM_CH];
  int m_nxt  [NUM_CH];
  bit m_ph   [NUM_CH];
  bit m_rel  [NUM_CH];
  bit m_rn   [NUM_CH];
  bit m_soft [NUM_CH];
  int m_soft_end [NUM_CH];
  int m_k;
  int m_wait_from;
  bit m_done;

  int rc = 0;
  bit prev_rst = 1'b1;

  function automatic logic [OW-1:0] pack(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] b,
                                         input logic [NUM_CH-1:0] c, input logic d);
    return {a, b, c, d};
  endfunction

  function automatic logic [NUM_CH*DIV_W-1:0] mk_cfg(input int d0, input int d1);
    logic [NUM_CH*DIV_W-1:0] c;
    c = '0;
    c[0 +: DIV_W]     = DIV_W'(d0);
    c[DIV_W +: DIV_W] = DIV_W'(d1);
    return c;
  endfunction

  function automatic bit m_en(input int i);
    return (m_nxt[i] == 0) || ((mt == m_term[i]) && !m_ph[i]);
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [NUM_CH-1:0] en, ph, rn;
    for (int i = 0; i < NUM_CH; i++) begin
      en[i] = m_en(i);
      ph[i] = m_ph[i];
      rn[i] = m_rn[i];
    end
    return pack(en, ph, rn, m_done);
  endfunction

  task automatic model_step(input logic rst, input logic [NUM_CH*DIV_W-1:0] cfg,
                            input logic [NUM_CH-1:0] srst);
    bit en [NUM_CH];
    bit fire;
    for (int i = 0; i < NUM_CH; i++) en[i] = m_en(i);
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_nxt[i]  = int'(cfg[i*DIV_W +: DIV_W]);
        m_term[i] = mt + 1 + m_nxt[i];
        m_ph[i]   = 0;
        m_rel[i]  = 0;
        m_rn[i]   = 0;
        m_soft[i] = 0;
        m_soft_end[i] = 0;
      end
      m_k = 0;
      m_wait_from = mt + 1 + RST_HOLD + 1;
      m_done = 0;
      m_valid = 1;
    end else begin
      fire = !m_done && (mt >= m_wait_from) && en[m_k];
      for (int i = 0; i < NUM_CH; i++) begin
        if (srst[i] && (m_rel[i] || (fire && m_k == i))) begin
          m_rn[i] = 0;
          m_soft[i] = 1;
          m_soft_end[i] = mt + 1 + RST_HOLD;
        end else if (fire && m_k == i) begin
          m_rn[i] = 1;
        end else if (m_soft[i] && mt >= m_soft_end[i] && en[i]) begin
          m_rn[i] = 1;
          m_soft[i] = 0;
        end
      end
      if (fire) begin
        m_rel[m_k] = 1;
        if (m_k == NUM_CH - 1) m_done = 1;
        else begin
          m_k++;
          m_wait_from = mt + 1 + RST_GAP + 1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (mt == m_term[i]) begin
          m_term[i] = mt + 1 + m_nxt[i];
          m_nxt[i]  = int'(cfg[i*DIV_W +: DIV_W]);
          m_ph[i]   = !m_ph[i];
        end
      end
    end
    mt++;
  endtask

  // Closed-form expectations for the directed runs, indexed by cycles since reset release.
  function automatic logic [OW-1:0] dir_exp(input int tag, input int c, output logic [OW-1:0] mask);
    logic [NUM_CH-1:0] en, ph, rn;
    logic dn;
    en[0] = (c % 4 == 1);
    en[1] = (c % 8 == 3);
    ph[0] = ((c / 2) % 2 == 1);
    ph[1] = ((c / 4) % 2 == 1);
    rn[0] = (c >= 6);
    rn[1] = (c >= 12);
    dn    = (c >= 12);
    mask  = '1;
    case (tag)
      2: begin
        en[0] = 1'b1;
        ph[0] = (c % 2 == 1);
        mask  = pack(2'b01, 2'b01, 2'b01, 1'b0);
      end
      3: begin
        en[0] = (c == 1) || (c == 5) || (c == 9) || (c == 17) || (c == 25) || (c == 33);
        mask  = pack(2'b01, 2'b00, 2'b00, 1'b0);
      end
      4: rn[0] = ((c >= 6) && (c < 21)) || (c >= 26);
      5: rn[0] = ((c >= 6) && (c < 21)) || (c >= 30);
      6: begin
        ph   = '0;
        rn   = '0;
        dn   = 1'b0;
        mask = pack(2'b00, 2'b11, 2'b11, 1'b1);
      end
      default: ;
    endcase
    return pack(en, ph, rn, dn);
  endfunction

  task automatic check(input string name, input int cyc, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp, input logic [OW-1:0] mask);
    n_checks++;
    if ((act & mask) !== (exp & mask)) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b mask=%b", name, cyc, act, exp, mask);
    end
  endtask

  task automatic cycle(input logic rst, input logic [NUM_CH*DIV_W-1:0] cfg,
                       input logic [NUM_CH-1:0] srst, input int tag);
    sb_t it;
    @(posedge ACLK);
    #1;
    ARESET   = rst;
    DIV_CFG  = cfg;
    SRST_REQ = srst;
    if (!rst && prev_rst) rc = 0;
    else rc = rc + 1;
    if (m_valid) begin
      it.exp = model_out();
      it.tag = tag;
      it.rc  = rc;
      it.mt  = mt;
      sb_q.push_back(it);
    end
    model_step(rst, cfg, srst);
    prev_rst = rst;
  endtask

  task automatic do_reset(input logic [NUM_CH*DIV_W-1:0] cfg, input int n);
    for (int j = 0; j < n; j++) cycle(1'b1, cfg, '0, 0);
  endtask

  function automatic int rand_d();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, DMAX));
    return int'($urandom_range(0, 4));
  endfunction

  // Monitor: the DUT presents a full output vector every cycle; compare it mid-cycle.
  initial begin : monitor
    sb_t it;
    logic [OW-1:0] act, dexp, dmask;
    forever begin
      @(negedge ACLK);
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {CLKEN, CLKPH, RESETN_OUT, SEQ_DONE};
        check("clken",  it.mt, act, it.exp, pack('1, '0, '0, 1'b0));
        check("clkph",  it.mt, act, it.exp, pack('0, '1, '0, 1'b0));
        check("resetn", it.mt, act, it.exp, pack('0, '0, '1, 1'b0));
        check("done",   it.mt, act, it.exp, pack('0, '0, '0, 1'b1));
        if (it.tag != 0) begin
          dexp = dir_exp(it.tag, it.rc, dmask);
          check($sformatf("plan%0d", it.tag), it.rc, act, dexp, dmask);
        end
      end
    end
  end

  initial begin : stimulus
    logic [NUM_CH*DIV_W-1:0] rcfg;
    logic [NUM_CH-1:0]       sr;
    logic                    rst;

    // Rates, phases and release order.
    do_reset(mk_cfg(1, 3), 3);
    for (int c = 0; c < 40; c++) cycle(1'b0, mk_cfg(1, 3), '0, 1);

    // Bypass on channel 0.
    do_reset(mk_cfg(0, 3), 3);
    for (int c = 0; c < 40; c++) cycle(1'b0, mk_cfg(0, 3), '0, 2);

    // Live divisor change 1 -> 3 on channel 0 at cycle 6.
    do_reset(mk_cfg(1, 3), 3);
    for (int c = 0; c < 40; c++) cycle(1'b0, (c >= 6) ? mk_cfg(3, 3) : mk_cfg(1, 3), '0, 3);

    // Soft reset after SEQ_DONE, single and repeated request.
    do_reset(mk_cfg(1, 3), 3);
    for (int c = 0; c < 40; c++) cycle(1'b0, mk_cfg(1, 3), (c == 20) ? 2'b01 : 2'b00, 4);
    do_reset(mk_cfg(1, 3), 3);
    for (int c = 0; c < 40; c++) cycle(1'b0, mk_cfg(1, 3), (c == 20 || c == 23) ? 2'b01 : 2'b00, 5);

    // ARESET during GAP, then the full sequence again.
    do_reset(mk_cfg(1, 3), 3);
    for (int c = 0; c < 8; c++) cycle(1'b0, mk_cfg(1, 3), '0, 1);
    cycle(1'b1, mk_cfg(1, 3), '0, 1);
    cycle(1'b1, mk_cfg(1, 3), '0, 6);
    cycle(1'b1, mk_cfg(1, 3), '0, 6);
    for (int c = 0; c < 40; c++) cycle(1'b0, mk_cfg(1, 3), '0, 1);

    // Ignored request on an unreleased channel, requests on release strobes.
    do_reset(mk_cfg(1, 3), 3);
    for (int c = 0; c < 45; c++)
      cycle(1'b0, mk_cfg(1, 3), (c == 3 || c == 5 || c == 20 || c == 25) ? 2'b01 : 2'b00, 0);

    // Randomised segments.
    for (int seg = 0; seg < 20; seg++) begin
      rcfg = mk_cfg(rand_d(), rand_d());
      do_reset(rcfg, int'($urandom_range(1, 3)));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 29) == 0) rcfg[$urandom_range(0, NUM_CH-1)*DIV_W +: DIV_W] = DIV_W'(rand_d());
        sr  = ($urandom_range(0, 19) == 0) ? NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)) : '0;
        rst = ($urandom_range(0, 299) == 0);
        cycle(rst, rcfg, sr, 0);
      end
    end

    cycle(1'b0, rcfg, '0, 0);
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge ACLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
